// File: rtl/qam16_slicer_ber.sv
// 16-QAM receive checker: slices I/Q samples into symbols, aligns them against
// the transmit symbol stream through a delay search, and counts symbol errors per window.
module qam16_slicer_ber #(
  parameter int MAX_DELAY    = 15,
  parameter int TRIAL_LEN    = 64,
  parameter int LOCK_ERR_MAX = 2,
  parameter int MEAS_LEN     = 1048576,
  parameter int LOSS_ERR_MAX = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_clk_en,
  input  logic [17:0] sig_inph,
  input  logic [17:0] sig_quad,
  input  logic [17:0] threshold,
  input  logic [3:0]  tx_sym,
  output logic [3:0]  rx_sym,
  output logic [3:0]  delay_sel,
  output logic        locked,
  output logic [21:0] err_count,
  output logic        window_done
);

  localparam int TW = $clog2(TRIAL_LEN + 1);
  localparam int MW = $clog2(MEAS_LEN + 1);
  localparam int FW = $clog2(MAX_DELAY + 2);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [3:0]          code_vec;
  logic signed [18:0]  thr_ext;
  logic [3:0]          rx_sym_reg;
  logic [3:0]          ref_pipe [0:MAX_DELAY];
  logic [3:0]          ref_sel;
  logic                sym_err;

  logic [1:0]          state_reg, state_next;
  logic [FW-1:0]       fill_reg, fill_next;
  logic [3:0]          delay_reg, delay_next, delay_inc;
  logic [TW-1:0]       trial_cnt_reg, trial_cnt_next;
  logic [TW-1:0]       trial_err_reg, trial_err_next, trial_err_sum;
  logic [MW-1:0]       meas_cnt_reg, meas_cnt_next;
  logic [21:0]         meas_err_reg, meas_err_next, meas_err_sum;
  logic [21:0]         err_count_reg, err_count_next;
  logic                locked_reg, locked_next;
  logic                window_done_reg, window_done_next;

  assign thr_ext = {1'b0, threshold};

  // Rail 1 is in-phase (symbol bits 3:2), rail 0 is quadrature (bits 1:0).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rail
      logic signed [18:0] x_ext;
      assign x_ext = (gi == 1) ? {sig_inph[17], sig_inph} : {sig_quad[17], sig_quad};
      assign code_vec[2*gi +: 2] = (x_ext >= thr_ext)   ? 2'b11 :
                                   (x_ext >= 19'sd0)    ? 2'b10 :
                                   (x_ext >= -thr_ext)  ? 2'b01 : 2'b00;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sym_reg <= '0;
      for (int k = 0; k <= MAX_DELAY; k++) ref_pipe[k] <= '0;
    end else if (sym_clk_en) begin
      rx_sym_reg  <= code_vec;
      ref_pipe[0] <= tx_sym;
      for (int k = 1; k <= MAX_DELAY; k++) ref_pipe[k] <= ref_pipe[k-1];
    end
  end

  assign ref_sel       = ref_pipe[delay_reg];
  assign sym_err       = (rx_sym_reg != ref_sel);
  assign trial_err_sum = trial_err_reg + TW'(sym_err);
  assign meas_err_sum  = (meas_err_reg == 22'h3FFFFF) ? meas_err_reg : meas_err_reg + 22'(sym_err);
  assign delay_inc     = (delay_reg == 4'(MAX_DELAY)) ? 4'd0 : delay_reg + 4'd1;

  always_comb begin
    state_next       = state_reg;
    fill_next        = fill_reg;
    delay_next       = delay_reg;
    trial_cnt_next   = trial_cnt_reg;
    trial_err_next   = trial_err_reg;
    meas_cnt_next    = meas_cnt_reg;
    meas_err_next    = meas_err_reg;
    err_count_next   = err_count_reg;
    locked_next      = locked_reg;
    window_done_next = 1'b0;
    if (sym_clk_en) begin
      case (state_reg)
        ST_FILL: begin
          if (fill_reg == FW'(MAX_DELAY)) begin
            state_next     = ST_SEARCH;
            delay_next     = 4'd0;
            trial_cnt_next = '0;
            trial_err_next = '0;
          end else begin
            fill_next = fill_reg + FW'(1);
          end
        end
        ST_SEARCH: begin
          if (trial_cnt_reg == TW'(TRIAL_LEN - 1)) begin
            trial_cnt_next = '0;
            trial_err_next = '0;
            if (trial_err_sum <= TW'(LOCK_ERR_MAX)) begin
              state_next    = ST_LOCKED;
              locked_next   = 1'b1;
              meas_cnt_next = '0;
              meas_err_next = '0;
            end else begin
              delay_next = delay_inc;
            end
          end else begin
            trial_cnt_next = trial_cnt_reg + TW'(1);
            trial_err_next = trial_err_sum;
          end
        end
        ST_LOCKED: begin
          if (meas_cnt_reg == MW'(MEAS_LEN - 1)) begin
            meas_cnt_next    = '0;
            meas_err_next    = '0;
            err_count_next   = meas_err_sum;
            window_done_next = 1'b1;
            // A window this bad means the alignment slipped: resume the search at the next tap.
            if (meas_err_sum > 22'(LOSS_ERR_MAX)) begin
              state_next     = ST_SEARCH;
              locked_next    = 1'b0;
              delay_next     = delay_inc;
              trial_cnt_next = '0;
              trial_err_next = '0;
            end
          end else begin
            meas_cnt_next = meas_cnt_reg + MW'(1);
            meas_err_next = meas_err_sum;
          end
        end
        default: state_next = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_FILL;
      fill_reg        <= '0;
      delay_reg       <= '0;
      trial_cnt_reg   <= '0;
      trial_err_reg   <= '0;
      meas_cnt_reg    <= '0;
      meas_err_reg    <= '0;
      err_count_reg   <= '0;
      locked_reg      <= 1'b0;
      window_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fill_reg        <= fill_next;
      delay_reg       <= delay_next;
      trial_cnt_reg   <= trial_cnt_next;
      trial_err_reg   <= trial_err_next;
      meas_cnt_reg    <= meas_cnt_next;
      meas_err_reg    <= meas_err_next;
      err_count_reg   <= err_count_next;
      locked_reg      <= locked_next;
      window_done_reg <= window_done_next;
    end
  end

  assign rx_sym      = rx_sym_reg;
  assign delay_sel   = delay_reg;
  assign locked      = locked_reg;
  assign err_count   = err_count_reg;
  assign window_done = window_done_reg;

endmodule

// File: tb/tb_qam16_slicer_ber.sv
// Directed bench for qam16_slicer_ber: slicer boundaries, delay search, window error counts,
// loss/relock, enable gating and asynchronous reset, with a queue of expected window totals.
module tb_qam16_slicer_ber;

  localparam int MEAS = 4096;
  localparam int DLY  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        sym_clk_en;
  logic [17:0] sig_inph;
  logic [17:0] sig_quad;
  logic [17:0] threshold;
  logic [3:0]  tx_sym;
  logic [3:0]  rx_sym;
  logic [3:0]  delay_sel;
  logic        locked;
  logic [21:0] err_count;
  logic        window_done;

  qam16_slicer_ber #(
    .MAX_DELAY(15), .TRIAL_LEN(64), .LOCK_ERR_MAX(2),
    .MEAS_LEN(MEAS), .LOSS_ERR_MAX(1024)
  ) dut (
    .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en),
    .sig_inph(sig_inph), .sig_quad(sig_quad), .threshold(threshold),
    .tx_sym(tx_sym), .rx_sym(rx_sym), .delay_sel(delay_sel), .locked(locked),
    .err_count(err_count), .window_done(window_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [3:0]  tx_hist [0:32767];
  int          g = 0;
  int          en_cnt = 0;
  bit          swap_rails = 1'b0;
  bit          win_active = 1'b0;
  int          win_end = 0;
  int          win_err = 0;
  logic [3:0]  prev_sent = 4'h0;
  logic [3:0]  prev_ideal = 4'h0;
  logic [21:0] exp_win_q [$];
  logic [3:0]  exp_rx_q [$];

  function automatic logic [17:0] amp(input logic [1:0] c);
    case (c)
      2'b11:   amp = 18'd131070;
      2'b10:   amp = 18'd43690;
      2'b01:   amp = 18'd218454;
      default: amp = 18'd131074;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One symbol: loopback sample delayed DLY symbols, optional rail swap / corruption.
  task automatic sym_step(input int gap, input bit corrupt);
    logic [3:0]  ideal;
    logic [3:0]  sent;
    logic [21:0] exp_v;
    tx_hist[g] = 4'($urandom_range(0, 15));
    ideal = (g >= DLY) ? tx_hist[g-DLY] : 4'h0;
    sent  = swap_rails ? {ideal[1:0], ideal[3:2]} : ideal;
    if (corrupt) sent = sent ^ 4'b1000;
    tx_sym     = tx_hist[g];
    sig_inph   = amp(sent[3:2]);
    sig_quad   = amp(sent[1:0]);
    sym_clk_en = 1'b1;
    if (win_active) begin
      win_err += (prev_sent != prev_ideal) ? 1 : 0;
      if (en_cnt + 1 == win_end) begin
        exp_win_q.push_back(22'(win_err));
        win_err = 0;
        win_end += MEAS;
      end
    end
    @(posedge clk);
    #1;
    sym_clk_en = 1'b0;
    en_cnt++;
    g++;
    prev_sent  = sent;
    prev_ideal = ideal;
    if (window_done) begin
      check("window_expected", (exp_win_q.size() > 0) ? 1 : 0, 1);
      if (exp_win_q.size() > 0) begin
        exp_v = exp_win_q.pop_front();
        check("window_err_count", err_count, exp_v);
      end
    end
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_until(input int target, input int gap);
    while (en_cnt < target) sym_step(gap, 1'b0);
  endtask

  task automatic slice_step(input logic [17:0] i_val, input logic [1:0] code);
    logic [3:0] exp_v;
    sig_inph = i_val;
    sig_quad = 18'd0;
    tx_sym   = 4'h0;
    exp_rx_q.push_back({code, 2'b10});
    sym_clk_en = 1'b1;
    @(posedge clk);
    #1;
    sym_clk_en = 1'b0;
    exp_v = exp_rx_q.pop_front();
    check("slicer", rx_sym, exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_sym"}, rx_sym, 0);
    check({tag, "_delay_sel"}, delay_sel, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_window_done"}, window_done, 0);
  endtask

  initial begin
    reset = 1'b1;
    sym_clk_en = 1'b0;
    sig_inph = '0;
    sig_quad = '0;
    threshold = 18'd87381;
    tx_sym = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_initial");
    reset = 1'b0;

    slice_step(18'd87381,  2'b11);
    slice_step(18'd87380,  2'b10);
    slice_step(18'd0,      2'b10);
    slice_step(18'h3FFFF,  2'b01);
    slice_step(18'd174763, 2'b01);
    slice_step(18'd174762, 2'b00);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    en_cnt = 0;

    // Search at one enable every 16 cycles, with a 100-cycle enable gap inside trial 1.
    run_until(100, 16);
    sig_inph = 18'd0;
    sig_quad = 18'd0;
    repeat (100) @(posedge clk);
    #1;
    check("gate_delay_sel", delay_sel, 1);
    check("gate_rx_sym", rx_sym, prev_sent);
    check("gate_locked", locked, 0);
    run_until(399, 16);
    check("prelock_locked", locked, 0);
    sym_step(16, 1'b0);
    check("lock_locked", locked, 1);
    check("lock_delay_sel", delay_sel, DLY);
    win_active = 1'b1;
    win_end = en_cnt + MEAS;
    win_err = 0;

    run_until(win_end - 1, 2);
    sym_step(1, 1'b0);
    check("win1_done", window_done, 1);
    check("win1_err", err_count, 0);
    @(posedge clk);
    #1;
    check("win1_pulse_width", window_done, 0);

    run_until(4600, 2);
    sym_step(2, 1'b1);
    run_until(4700, 2);
    sym_step(2, 1'b1);
    run_until(4800, 2);
    sym_step(2, 1'b1);
    run_until(400 + 2*MEAS, 2);
    check("win2_err", err_count, 3);
    check("win2_locked", locked, 1);

    run_until(400 + 3*MEAS, 2);
    check("win3_err", err_count, 0);

    swap_rails = 1'b1;
    run_until(400 + 4*MEAS, 2);
    win_active = 1'b0;
    check("loss_locked", locked, 0);
    check("loss_delay_sel", delay_sel, DLY + 1);
    check("loss_err_over", (err_count > 22'd1024) ? 1 : 0, 1);

    swap_rails = 1'b0;
    run_until(400 + 4*MEAS + 16*64 - 1, 2);
    check("relock_pre_locked", locked, 0);
    sym_step(2, 1'b0);
    check("relock_locked", locked, 1);
    check("relock_delay_sel", delay_sel, DLY);

    run_until(en_cnt + 10, 2);
    reset = 1'b1;
    #2;
    check_reset_outputs("reset_async");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    reset = 1'b0;
    en_cnt = 0;
    run_until(399, 2);
    check("post_reset_prelock", locked, 0);
    sym_step(2, 1'b0);
    check("post_reset_locked", locked, 1);
    check("post_reset_delay_sel", delay_sel, DLY);

    check("window_queue_empty", exp_win_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qam16_slicer_ber.md
# qam16_slicer_ber

Receive-side checker for the 16-QAM test path. It slices downsampled in-phase and quadrature samples into 4-bit symbols, and aligns them against the locally generated transmit symbol stream (the LFSR `sym_out`) by searching a delay line. Once aligned, it counts symbol errors over fixed measurement windows. It sits after the receive downsampler in sanity and loopback tops and drives LEDs and SignalTap probes.

## Interface
Parameters:
- `MAX_DELAY`, 15: largest delay tap searched (delay line depth `MAX_DELAY+1`).
- `TRIAL_LEN`, 64: compares per delay trial during search.
- `LOCK_ERR_MAX`, 2: maximum trial errors allowed to declare lock.
- `MEAS_LEN`, 1048576: compares per measurement window when locked.
- `LOSS_ERR_MAX`, 262144: a window error total above this drops lock.

Ports:
- `clk` in 1: system clock (`sys_clk`).
- `reset` in 1: asynchronous, active-high.
- `sym_clk_en` in 1: symbol-rate enable; all state advances only when it is high.
- `sig_inph` in 18: signed 1s17 received in-phase sample.
- `sig_quad` in 18: signed 1s17 received quadrature sample.
- `threshold` in 18: unsigned inner/outer decision threshold.
- `tx_sym` in 4: reference transmit symbol.
- `rx_sym` out 4: sliced symbol.
- `delay_sel` out 4: current delay tap.
- `locked` out 1: alignment achieved.
- `err_count` out 22: error total of the last completed window.
- `window_done` out 1: one-cycle pulse when `err_count` updates.

## Operation
- **Slicer**, per rail. Compare in 19-bit signed, with `threshold` zero-extended:
  - x ≥ thr → 2'b11
  - 0 ≤ x < thr → 2'b10
  - −thr ≤ x < 0 → 2'b01
  - x < −thr → 2'b00
- `rx_sym` = {I code, Q code}, registered on `sym_clk_en`.
- **Reference pipe**, on each `sym_clk_en`:
  - `ref_pipe[0] <= tx_sym`
  - `ref_pipe[k] <= ref_pipe[k-1]`
- **Compare**, on each `sym_clk_en` outside FILL: error = (`rx_sym` != `ref_pipe[delay_sel]`), using the registered values. Samples at enable n that carry `tx_sym` from enable n−d match when `delay_sel` = d.
- **FSM states:**
  - **FILL**: count `MAX_DELAY+1` enables, then go to SEARCH with `delay_sel`=0.
  - **SEARCH**: accumulate trial errors over `TRIAL_LEN` compares.
    - At trial end, if errors ≤ `LOCK_ERR_MAX`, go to LOCKED and clear the window accumulators.
    - Otherwise increment `delay_sel`, wrapping `MAX_DELAY`→0, clear the trial counters and stay in SEARCH.
  - **LOCKED**: accumulate the error count (saturating at 2^22−1) and the compare count.
    - On the `MEAS_LEN`-th compare, load `err_count` with the total including that compare, pulse `window_done`, and clear the accumulators.
    - If that total > `LOSS_ERR_MAX`, go to SEARCH with `delay_sel` incremented (wrapping) and `locked` deasserted.
- `sym_clk_en` low: every register holds.
- Reset mid-operation returns all state to reset values immediately.

## Timing
- Reset values:
  - `rx_sym`=0, `delay_sel`=0, `locked`=0, `err_count`=0, `window_done`=0.
  - Pipe cleared; state FILL.
- Slicer latency: 1 enabled cycle.
- `locked`, `delay_sel` and `err_count` change on the clock edge where the deciding compare occurs. They are visible the following cycle.
- `window_done` is high for exactly one `clk` cycle, not one symbol period.
- Lock latency for true delay d (no errors): lock is decided at enable `MAX_DELAY+1 + (d+1)*TRIAL_LEN`.
- Trial boundary and lock decision coinciding with reset: reset wins.

## Test plan
- **Reset:** assert `reset` mid-LOCKED → all outputs zero next cycle, state FILL, `locked`=0.
- **Slicer boundaries:** `threshold`=87381, Q=0 → I=87381 gives `rx_sym[3:2]`=11; 87380→10; 0→10; −1→01; −87381→01; −87382→00.
- **Loopback alignment:** ideal mapped LFSR symbols delayed 5 symbols, `sym_clk_en` every 16 cycles → `locked` rises after enable 400, `delay_sel`=5; with `MEAS_LEN`=4096, the first `window_done` reports `err_count`=0.
- **Error counting:** `MEAS_LEN`=4096, locked; corrupt exactly 3 symbols in one window → `err_count`=3, `locked` stays 1; next clean window → 0.
- **Loss of lock:** `MEAS_LEN`=4096, `LOSS_ERR_MAX`=1024; swap the I/Q rails after lock → at window end `locked`=0, `delay_sel`=6; restoring the rails relocks at `delay_sel`=5 after wrap.
- **Enable gating:** hold `sym_clk_en` low for 100 cycles mid-trial → `delay_sel`, counts and outputs unchanged; the trial resumes on the next enable.
